// File: rtl/ky32_irq_encoder8x3.sv
// Registered 8-to-3 priority encoder: rising edges on req are captured into pending, and the lowest eligible index is presented until acked.
// Latency: 2 cycles from a req edge to valid. Backpressure: the presented code holds until ack, with one IDLE cycle between codes.
module ky32_irq_encoder8x3 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_req,
    input  logic [7:0] i_mask,
    input  logic       i_ena,
    input  logic       i_ack,
    output logic [2:0] o_code,
    output logic       o_valid,
    output logic [7:0] o_pending,
    output logic [7:0] o_ovf
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_req_q;
    logic [7:0] r_pending;
    logic [7:0] r_ovf;
    logic [2:0] r_code;
    logic       r_valid;

    logic [7:0] w_rise;
    logic [7:0] w_set;
    logic [7:0] w_clr;
    logic [7:0] w_elig;
    logic [2:0] w_winner;
    logic [2:0] w_code_nxt;
    logic       w_valid_nxt;
    logic       w_do_clr;

    assign w_rise = i_req & ~r_req_q;
    assign w_set  = i_ena ? w_rise : 8'h00;
    assign w_elig = r_pending & ~i_mask;

    // Lowest index wins: scan from the top so bit 0 overrides last.
    always_comb begin
        w_winner = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_winner = 3'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        w_valid_nxt = r_valid;
        w_do_clr    = 1'b0;
        case (r_state)
            IDLE: begin
                w_valid_nxt = 1'b0;
                if (i_ena && (w_elig != 8'h00)) begin
                    w_code_nxt  = w_winner;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                if (i_ack) begin
                    w_do_clr    = 1'b1;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_clr = w_do_clr ? (8'h01 << r_code) : 8'h00;

    // A rise on the line being acked re-arms pending but counts as a fresh event, so ovf clears.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_req_q   <= 8'h00;
            r_pending <= 8'h00;
            r_ovf     <= 8'h00;
            r_code    <= 3'd0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_req_q   <= i_req;
            r_pending <= (r_pending & ~w_clr) | w_set;
            r_ovf     <= (r_ovf | (w_set & r_pending)) & ~w_clr;
            r_code    <= w_code_nxt;
            r_valid   <= w_valid_nxt;
        end
    end

    assign o_code    = r_code;
    assign o_valid   = r_valid;
    assign o_pending = r_pending;
    assign o_ovf     = r_ovf;

endmodule

// File: tb/tb_ky32_irq_encoder8x3.sv
// Directed bench for ky32_irq_encoder8x3 with hand-computed expectations.
`timescale 1ns/1ps
module tb_ky32_irq_encoder8x3;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ena;
    logic       ack;
    logic [2:0] code;
    logic       valid;
    logic [7:0] pending;
    logic [7:0] ovf;

    int checks = 0;
    int errors = 0;

    ky32_irq_encoder8x3 dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req     (req),
        .i_mask    (mask),
        .i_ena     (ena),
        .i_ack     (ack),
        .o_code    (code),
        .o_valid   (valid),
        .o_pending (pending),
        .o_ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [2:0] c,
                           input logic [7:0] p, input logic [7:0] o);
        chk({tag, ".valid"}, {7'd0, valid}, {7'd0, v});
        chk({tag, ".code"}, {5'd0, code}, {5'd0, c});
        chk({tag, ".pending"}, pending, p);
        chk({tag, ".ovf"}, ovf, o);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 8'h04;
        mask  = 8'h00;
        ena   = 1'b1;
        ack   = 1'b0;

        // Reset and first edge after release
        #12;
        chk_all("reset", 1'b0, 3'd0, 8'h00, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_all("released", 1'b0, 3'd0, 8'h00, 8'h00);
        step();
        chk_all("first_edge", 1'b0, 3'd0, 8'h04, 8'h00);
        step();
        chk_all("first_present", 1'b1, 3'd2, 8'h04, 8'h00);
        ack = 1'b1; step();
        chk_all("first_ack", 1'b0, 3'd2, 8'h00, 8'h00);
        ack = 1'b0; req = 8'h00; step();
        chk({"idle_after_ack.valid"}, {7'd0, valid}, 8'h00);

        // Priority and hold
        req = 8'h90; step();
        req = 8'h00; step();
        chk_all("prio_present4", 1'b1, 3'd4, 8'h90, 8'h00);
        req = 8'h02; step();
        req = 8'h00; step();
        chk_all("prio_hold4", 1'b1, 3'd4, 8'h92, 8'h00);
        ack = 1'b1; step();
        chk_all("prio_ack4", 1'b0, 3'd4, 8'h82, 8'h00);
        ack = 1'b0; step();
        chk_all("prio_present1", 1'b1, 3'd1, 8'h82, 8'h00);
        ack = 1'b1; step();
        ack = 1'b0; step();
        chk_all("prio_present7", 1'b1, 3'd7, 8'h80, 8'h00);
        ack = 1'b1; step();
        chk_all("prio_drain", 1'b0, 3'd7, 8'h00, 8'h00);
        ack = 1'b0;

        // Mask
        mask = 8'h01; req = 8'h09; step();
        req = 8'h00; step();
        chk_all("mask_present3", 1'b1, 3'd3, 8'h09, 8'h00);
        ack = 1'b1; step();
        chk_all("mask_ack3", 1'b0, 3'd3, 8'h01, 8'h00);
        ack = 1'b0; mask = 8'h00; step();
        chk_all("unmask_present0", 1'b1, 3'd0, 8'h01, 8'h00);
        ack = 1'b1; step();
        ack = 1'b0;

        // Enable low: edge is not captured
        ena = 1'b0; req = 8'h20; step();
        req = 8'h00; step();
        chk_all("ena_off", 1'b0, 3'd0, 8'h00, 8'h00);
        ena = 1'b1; step();
        chk_all("ena_back", 1'b0, 3'd0, 8'h00, 8'h00);

        // Overrun
        req = 8'h40; step();
        req = 8'h00; step();
        req = 8'h40; step();
        req = 8'h00; step();
        chk_all("ovf_set", 1'b1, 3'd6, 8'h40, 8'h40);
        ack = 1'b1; step();
        chk_all("ovf_ack", 1'b0, 3'd6, 8'h00, 8'h00);
        ack = 1'b0;

        // Simultaneous rise and ack on the presented line
        req = 8'h04; step();
        req = 8'h00; step();
        chk_all("sim_present2", 1'b1, 3'd2, 8'h04, 8'h00);
        req = 8'h04; ack = 1'b1; step();
        chk_all("sim_setwins", 1'b0, 3'd2, 8'h04, 8'h00);
        ack = 1'b0; step();
        chk_all("sim_represent2", 1'b1, 3'd2, 8'h04, 8'h00);
        req = 8'h00; ack = 1'b1; step();
        chk_all("sim_drain", 1'b0, 3'd2, 8'h00, 8'h00);
        ack = 1'b0;

        // Async reset mid-presentation
        req = 8'h10; step();
        req = 8'h00; step();
        req = 8'h10; step();
        req = 8'h00; step();
        chk_all("pre_rst", 1'b1, 3'd4, 8'h10, 8'h10);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 3'd0, 8'h00, 8'h00);
        rst_n = 1'b1;
        ack = 1'b1; step();
        chk_all("ack_idle", 1'b0, 3'd0, 8'h00, 8'h00);
        ack = 1'b0; step();
        chk_all("idle_stays", 1'b0, 3'd0, 8'h00, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ky32_irq_encoder8x3.md
# ky32_irq_encoder8x3

Registered 8-to-3 priority encoder with a request/acknowledge handshake: the counterpart to the KY32 3x8 enable decoder. It captures rising edges on eight request lines into a pending register and presents the highest-priority eligible index as a 3-bit code with a valid flag. The code is held until the consumer acknowledges it. It sits in front of the KY32 interrupt/selection logic, and its code output feeds the 3x8 decoder directly.

## Interface
No parameters; all widths are fixed (8 requests, 3-bit code).

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low
- req  in  8  request lines, level signals, edge-detected internally
- mask  in  8  1 = line excluded from arbitration; the edge is still captured
- ena  in  1  block enable, same meaning as the decoder's enable
- ack  in  1  consumer acknowledge of the presented code
- code  out  3  presented index, registered
- valid  out  1  code is valid, registered
- pending  out  8  captured, not-yet-acknowledged events
- ovf  out  8  sticky per-line overrun: an edge arrived while that line was already pending

## Operation
- Edge capture
  - req_q (8 bits) registers req every cycle.
  - rise = req & ~req_q.
  - When ena=1, pending[i] sets on rise[i].
  - When ena=0, no new events are captured, but req_q keeps tracking req.
- Overrun: rise[i] with pending[i] already 1 and ena=1 sets ovf[i]. The event itself is merged into the existing pending bit, not queued.
- Eligibility: elig = pending & ~mask.
- Priority: bit 0 has the highest priority, bit 7 the lowest. The winner is the lowest-index 1 in elig.
- FSM states: IDLE and PRESENT.
  - IDLE, ena=1 and elig≠0: load code with the winner, set valid=1, go to PRESENT.
  - IDLE, otherwise: valid=0, stay in IDLE.
  - PRESENT: code and valid are frozen.
    - Mask changes, ena deassertion and higher-priority arrivals do not retract or alter the presented code.
  - PRESENT with ack=1: clear pending[code] and ovf[code], set valid=0, go to IDLE.
- ack while in IDLE is ignored, with no state change.
- Simultaneous rise[code] and ack on the same cycle: the set wins.
  - pending[code] remains 1.
  - ovf[code] is cleared. The new event is a fresh event, not an overrun.
- Clearing a line never affects other lines' pending or ovf bits.

## Timing
- Reset (async, rst_n=0) forces:
  - code=3'b000, valid=0, pending=8'h00, ovf=8'h00, req_q=8'h00, state=IDLE.
- Release: a req line already high at the first clk edge after rst_n rises counts as a rising edge.
- Reset mid-presentation: valid drops asynchronously and all captured events are lost.
- Latency from a req rising at the input:
  - The edge is sampled at clk edge N, and pending is set after edge N.
  - valid=1 with its code after edge N+1, i.e. 2 cycles.
- Handshake: ack is sampled at a clk edge while valid=1, and valid=0 after that edge.
- Throughput:
  - After an ack, the next eligible code is presented one cycle later, because IDLE always takes one cycle.
  - Maximum rate is one code per 2 cycles with ack held high.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset/first edge: hold req=8'h04 through reset, release rst_n → pending=8'h04 after 1 edge; valid=1, code=3'd2 after 2 edges; earlier outputs all 0.
- Priority and hold: pending=8'h90, present code=4; then pulse req[1] → code stays 4 until ack; after ack next presentation code=1, then code=7.
- Mask and enable:
  - mask=8'h01 with req[0] and req[3] rising → code=3. Unmask after the ack → code=0.
  - With ena=0, pulse req[5] → pending unchanged and valid stays 0.
- Overrun: pulse req[6] twice without ack → ovf=8'h40. ack of code=6 → pending[6]=0 and ovf=8'h00.
- Simultaneous set/clear: presenting code=2, assert ack in the same cycle as a new rise on req[2] → pending[2]=1, ovf[2]=0, valid=0, then code=2 is presented again 1 cycle later.
- Async reset mid-PRESENT: drop rst_n between clk edges while valid=1 → valid, pending and ovf go to 0 immediately; ack in IDLE afterwards has no effect.
